// File: rtl/unidad_fetch_pkg.sv
// rtl/unidad_fetch_pkg.sv - shared constants and state encoding for the fetch stage
package unidad_fetch_pkg;

    localparam int ANCHO_INSTR   = 32;
    localparam int INCREMENTO_PC = 4;

    // Bubble word; decode treats it as a no-op when if_valid is low.
    localparam logic [ANCHO_INSTR-1:0] INSTR_NOP = 32'h0000_0000;

    typedef enum logic {
        CORRIENDO = 1'b0,
        DETENIDO  = 1'b1
    } estado_fetch_t;

endpackage

// File: rtl/unidad_fetch_registro_if_id.sv
// rtl/unidad_fetch_registro_if_id.sv - pipeline register {instr, pc, pc+4} with valid, load and flush
module registro_if_id
    import unidad_fetch_pkg::*;
#(
    parameter int ANCHO_PC = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic                   flush,
    input  logic [ANCHO_INSTR-1:0] instr_in,
    input  logic [ANCHO_PC-1:0]    pc_in,
    input  logic [ANCHO_PC-1:0]    pc_mas4_in,
    output logic                   valid,
    output logic [ANCHO_INSTR-1:0] instr,
    output logic [ANCHO_PC-1:0]    pc,
    output logic [ANCHO_PC-1:0]    pc_mas4
);

    logic                   valid_q, valid_d;
    logic [ANCHO_INSTR-1:0] instr_q, instr_d;
    logic [ANCHO_PC-1:0]    pc_q, pc_d;
    logic [ANCHO_PC-1:0]    pc_mas4_q, pc_mas4_d;

    // Flush only drops valid; the payload fields keep their last contents.
    always_comb begin
        valid_d   = valid_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        pc_mas4_d = pc_mas4_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d   = 1'b1;
            instr_d   = instr_in;
            pc_d      = pc_in;
            pc_mas4_d = pc_mas4_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            instr_q   <= INSTR_NOP;
            pc_q      <= '0;
            pc_mas4_q <= '0;
        end else begin
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            pc_mas4_q <= pc_mas4_d;
        end
    end

    assign valid   = valid_q;
    assign instr   = instr_q;
    assign pc      = pc_q;
    assign pc_mas4 = pc_mas4_q;

endmodule

// File: rtl/unidad_fetch.sv
// rtl/unidad_fetch.sv - instruction fetch stage: PC, next-PC mux, IF/ID register; FETCH_TRAP_DESALINEADO_EN adds misaligned-redirect trap
module unidad_fetch
    import unidad_fetch_pkg::*;
#(
    parameter int                  ANCHO_PC = 6,
    parameter logic [ANCHO_PC-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
`ifdef FETCH_TRAP_DESALINEADO_EN
    output logic                   err_desalineado,
`endif
    output logic [ANCHO_PC-1:0]    addr_byte,
    input  logic [ANCHO_INSTR-1:0] instruccion,
    input  logic                   id_ready,
    input  logic                   salto_valido,
    input  logic [ANCHO_PC-1:0]    salto_destino,
    output logic                   if_valid,
    output logic [ANCHO_INSTR-1:0] if_instr,
    output logic [ANCHO_PC-1:0]    if_pc,
    output logic [ANCHO_PC-1:0]    if_pc_mas4
);

    localparam logic [ANCHO_PC-1:0] INC     = ANCHO_PC'(INCREMENTO_PC);
    localparam logic [ANCHO_PC-1:0] MASCARA = ~ANCHO_PC'(3);

    logic [ANCHO_PC-1:0] pc_q, pc_d;
    logic                load, flush, avanza;

`ifdef FETCH_TRAP_DESALINEADO_EN
    estado_fetch_t estado_q, estado_d;
    logic          err_q, err_d;
`endif

    assign avanza = !if_valid || id_ready;

    always_comb begin
        pc_d  = pc_q;
        load  = 1'b0;
        flush = 1'b0;
`ifdef FETCH_TRAP_DESALINEADO_EN
        estado_d = estado_q;
        err_d    = err_q;
        if (estado_q == DETENIDO) begin
            // Sticky trap: nothing moves until reset.
        end else if (salto_valido && (salto_destino[1:0] != 2'b00)) begin
            estado_d = DETENIDO;
            err_d    = 1'b1;
            flush    = 1'b1;
        end else
`endif
        if (salto_valido) begin
            pc_d  = salto_destino & MASCARA;
            flush = 1'b1;
        end else if (avanza) begin
            pc_d = pc_q + INC;
            load = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
`ifdef FETCH_TRAP_DESALINEADO_EN
            estado_q <= CORRIENDO;
            err_q    <= 1'b0;
`endif
        end else begin
            pc_q <= pc_d;
`ifdef FETCH_TRAP_DESALINEADO_EN
            estado_q <= estado_d;
            err_q    <= err_d;
`endif
        end
    end

`ifdef FETCH_TRAP_DESALINEADO_EN
    assign err_desalineado = err_q;
`endif

    assign addr_byte = pc_q;

    registro_if_id #(
        .ANCHO_PC (ANCHO_PC)
    ) u_registro_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .flush      (flush),
        .instr_in   (instruccion),
        .pc_in      (pc_q),
        .pc_mas4_in (pc_q + INC),
        .valid      (if_valid),
        .instr      (if_instr),
        .pc         (if_pc),
        .pc_mas4    (if_pc_mas4)
    );

endmodule

// File: tb/tb_unidad_fetch.sv
// tb/tb_unidad_fetch.sv - scoreboard bench for unidad_fetch with a combinational ROM model
module tb_unidad_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  addr_byte;
    logic [31:0] instruccion;
    logic        id_ready;
    logic        salto_valido;
    logic [5:0]  salto_destino;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [5:0]  if_pc;
    logic [5:0]  if_pc_mas4;
`ifdef FETCH_TRAP_DESALINEADO_EN
    logic        err_desalineado;
`endif

    logic [31:0] rom [16];
    int          n_cmp = 0;
    int          n_err = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [5:0]  pc;
        logic [5:0]  pc_mas4;
    } transfer_t;

    transfer_t esperado_q[$];

    always #5 clk = ~clk;

    assign instruccion = rom[addr_byte[5:2]];

    unidad_fetch #(
        .ANCHO_PC (6),
        .RESET_PC (6'd0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
`ifdef FETCH_TRAP_DESALINEADO_EN
        .err_desalineado (err_desalineado),
`endif
        .addr_byte     (addr_byte),
        .instruccion   (instruccion),
        .id_ready      (id_ready),
        .salto_valido  (salto_valido),
        .salto_destino (salto_destino),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_pc_mas4    (if_pc_mas4)
    );

    task automatic chk(input string nombre, input logic [31:0] actual, input logic [31:0] requerido);
        n_cmp++;
        if (actual !== requerido) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nombre, actual, requerido, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [5:0] pc);
        transfer_t t;
        t.instr   = rom[pc[5:2]];
        t.pc      = pc;
        t.pc_mas4 = pc + 6'd4;
        esperado_q.push_back(t);
    endtask

    // Monitor: every accepted IF/ID transfer is checked against the scoreboard.
    initial begin
        transfer_t t;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && if_valid === 1'b1 && id_ready === 1'b1) begin
                if (esperado_q.size() == 0) begin
                    chk("unexpected_transfer_pc", {26'd0, if_pc}, 32'hFFFF_FFFF);
                end else begin
                    t = esperado_q.pop_front();
                    chk("sb_instr", if_instr, t.instr);
                    chk("sb_pc", {26'd0, if_pc}, {26'd0, t.pc});
                    chk("sb_pc_mas4", {26'd0, if_pc_mas4}, {26'd0, t.pc_mas4});
                end
            end
        end
    end

    initial begin
        rom[0] = 32'h2010_0001;
        rom[1] = 32'h8C11_0004;
        rom[2] = 32'h012A_4020;
        rom[3] = 32'h014B_4822;
        rom[4] = 32'h0232_8020;
        rom[5] = 32'hAC12_0010;
        for (int i = 6; i < 16; i++) rom[i] = 32'h3C00_0000 + 32'(i);

        rst_n = 1'b0; id_ready = 1'b0; salto_valido = 1'b0; salto_destino = 6'd0;
        tick(); tick();
        chk("rst_addr", {26'd0, addr_byte}, 32'd0);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_pc", {26'd0, if_pc}, 32'd0);
        chk("rst_pc_mas4", {26'd0, if_pc_mas4}, 32'd0);

        rst_n = 1'b1; id_ready = 1'b1;
        chk("c0_valid", {31'd0, if_valid}, 32'd0);
        tick();
        chk("c1_instr", if_instr, 32'h2010_0001);
        chk("c1_addr", {26'd0, addr_byte}, 32'd4);
        chk("c1_valid", {31'd0, if_valid}, 32'd1);
        push(6'd0);
        tick();
        chk("c2_instr", if_instr, 32'h8C11_0004);
        chk("c2_addr", {26'd0, addr_byte}, 32'd8);
        push(6'd4);
        tick();
        chk("c3_pc", {26'd0, if_pc}, 32'd8);
        id_ready = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_instr", if_instr, 32'h012A_4020);
            chk("stall_addr", {26'd0, addr_byte}, 32'd12);
            chk("stall_valid", {31'd0, if_valid}, 32'd1);
        end
        id_ready = 1'b1;
        push(6'd8);
        tick();
        chk("post_stall_instr", if_instr, 32'h014B_4822);
        chk("post_stall_pc", {26'd0, if_pc}, 32'd12);

        id_ready = 1'b0; salto_valido = 1'b1; salto_destino = 6'd20;
        tick();
        chk("redir_bubble", {31'd0, if_valid}, 32'd0);
        chk("redir_addr", {26'd0, addr_byte}, 32'd20);
        salto_valido = 1'b0; id_ready = 1'b1;
        tick();
        chk("redir_instr", if_instr, 32'hAC12_0010);
        chk("redir_pc", {26'd0, if_pc}, 32'd20);
        push(6'd20);

        for (int pc = 24; pc <= 60; pc += 4) begin
            tick();
            push(6'(pc));
        end
        chk("wrap_pc", {26'd0, if_pc}, 32'd60);
        chk("wrap_pc_mas4", {26'd0, if_pc_mas4}, 32'd0);
        chk("wrap_addr", {26'd0, addr_byte}, 32'd0);
        tick();
        chk("wrap_instr", if_instr, 32'h2010_0001);
        chk("wrap_if_pc", {26'd0, if_pc}, 32'd0);
        push(6'd0);

        for (int pc = 4; pc <= 24; pc += 4) begin
            tick();
            push(6'(pc));
        end
        tick();
        id_ready = 1'b0;
        tick();
        chk("stall32_addr", {26'd0, addr_byte}, 32'd32);
        rst_n = 1'b0;
        tick();
        chk("midrst_addr", {26'd0, addr_byte}, 32'd0);
        chk("midrst_valid", {31'd0, if_valid}, 32'd0);
        chk("midrst_instr", if_instr, 32'd0);
        chk("midrst_pc", {26'd0, if_pc}, 32'd0);
        chk("midrst_pc_mas4", {26'd0, if_pc_mas4}, 32'd0);

        rst_n = 1'b1; salto_valido = 1'b1; salto_destino = 6'h16;
        tick();
        salto_valido = 1'b0;
`ifdef FETCH_TRAP_DESALINEADO_EN
        chk("trap_err", {31'd0, err_desalineado}, 32'd1);
        chk("trap_addr", {26'd0, addr_byte}, 32'd0);
        chk("trap_valid", {31'd0, if_valid}, 32'd0);
        id_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            salto_valido = i[0];
            salto_destino = 6'd8;
            tick();
            chk("frozen_valid", {31'd0, if_valid}, 32'd0);
            chk("frozen_addr", {26'd0, addr_byte}, 32'd0);
            chk("frozen_err", {31'd0, err_desalineado}, 32'd1);
        end
        salto_valido = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("trap_rst_err", {31'd0, err_desalineado}, 32'd0);
        chk("trap_rst_addr", {26'd0, addr_byte}, 32'd0);
`else
        chk("mask_addr", {26'd0, addr_byte}, 32'h14);
        chk("mask_valid", {31'd0, if_valid}, 32'd0);
        tick();
        chk("mask_instr", if_instr, 32'hAC12_0010);
        chk("mask_pc", {26'd0, if_pc}, 32'd20);
`endif

        id_ready = 1'b0;
        tick(); tick();
        chk("scoreboard_drained", 32'(esperado_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/unidad_fetch.md
Name: unidad_fetch

Overview:
- Instruction-fetch stage that sits directly upstream of MemoriaInstrucciones.
- Owns the program counter and drives the ROM's 6-bit byte address; the ROM returns its 32-bit word combinationally.
- Registers that word, its PC and PC+4 into an IF/ID pipeline register with a valid/ready handshake toward decode.
- Accepts a branch/jump redirect that flushes the in-flight word.

Parameters:
- ANCHO_PC, 6, PC/byte-address width; must match the instruction-memory address width.
- RESET_PC, 0, PC value loaded on reset; must be word aligned (multiple of 4).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- addr_byte  output  ANCHO_PC  byte address to instruction memory; equals pc_q combinationally.
- instruccion  input  32  word returned by instruction memory for addr_byte, same cycle.
- id_ready  input  1  decode accepts the IF/ID contents this cycle.
- salto_valido  input  1  redirect request (taken branch/jump).
- salto_destino  input  ANCHO_PC  redirect target byte address.
- if_valid  output  1  IF/ID register holds a valid instruction.
- if_instr  output  32  registered instruction.
- if_pc  output  ANCHO_PC  address the instruction was fetched from.
- if_pc_mas4  output  ANCHO_PC  if_pc+4, modulo 2^ANCHO_PC.
- err_desalineado  output  1  misaligned-redirect flag; present only with the optional feature, otherwise absent.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n), sampled on the rising edge and taking priority over everything else.
- Reset values: pc_q=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_pc_mas4=0, err_desalineado=0.
- Transfer: avanza = (!if_valid) || id_ready.
- Priority each rising edge, when not in reset:
  1. salto_valido=1 (redirect): pc_q<=salto_destino with bits[1:0] forced to 00; if_valid<=0 (flush). Other IF/ID fields hold. Redirect wins over id_ready=0 (stall).
  2. Else, avanza=1 (fetch): if_instr<=instruccion, if_pc<=pc_q, if_pc_mas4<=pc_q+4, if_valid<=1, pc_q<=pc_q+4.
  3. Else (stall): all registers hold; addr_byte stays stable.
- Latency: the word at address A appears on if_instr one cycle after pc_q==A.
- Throughput: one instruction per cycle while id_ready=1.
- Redirect penalty: exactly one bubble (if_valid=0 for one cycle). Target instruction is valid on the second edge after salto_valido.
- Wrap-around: pc arithmetic is ANCHO_PC-bit unsigned. 60+4 -> 0; if_pc_mas4 wraps identically. No overflow flag.
- Reset mid-stall or mid-redirect: the reset values above apply on that edge; the pending redirect is lost.
- No combinational path from id_ready or salto_valido to addr_byte; addr_byte depends on pc_q only.

Optional Feature:
- Macro: FETCH_TRAP_DESALINEADO_EN.
- Defined:
  - Adds a 2-state FSM: CORRIENDO (reset state) and DETENIDO.
  - In CORRIENDO, a redirect with salto_destino[1:0]!=0 moves to DETENIDO; err_desalineado<=1, if_valid<=0, pc_q holds its old value, bits are not masked.
  - DETENIDO is sticky: no fetch, no redirect, all outputs hold. Only rst_n leaves it.
  - Aligned redirects behave as in the base behaviour.
- Undefined: no FSM and no err_desalineado port; low bits are silently masked.

Decomposition:
- Shared package/include holds:
  - ANCHO_INSTR=32.
  - INCREMENTO_PC=4.
  - State encoding CORRIENDO=1'b0, DETENIDO=1'b1.
  - NOP word 32'h0000_0000, shared with decode for bubble handling.
- One natural sub-module: registro_if_id.
  - Inputs: load, flush, and {instr, pc, pc_mas4}.
  - Output: valid.
  - Reused by later pipeline registers.
- PC register, next-PC mux and FSM stay in unidad_fetch.

Test Plan:
- Reset then free-run with id_ready=1 against the real ROM -> addr_byte 0,4,8,...; if_instr 0x20100001 at cycle 1, 0x8C110004 at cycle 2, 0xAC120010 at cycle 6; if_valid=0 only in cycle 0.
- Hold id_ready=0 for 3 cycles while if_pc=8 -> if_instr=0x012A4020, addr_byte=12 and if_valid=1 stable for all 3 cycles; the next instruction is 0x014B4822, with no duplicate and no skip.
- Assert salto_valido with salto_destino=20 while id_ready=0 and if_valid=1 -> next cycle if_valid=0 and addr_byte=20; the following cycle if_instr=0xAC120010, if_pc=20.
- Free-run to pc=60 -> if_pc_mas4=0 and next addr_byte=0; if_instr returns to 0x20100001.
- Redirect to 0x16:
  - Macro undefined -> addr_byte=0x14.
  - Macro defined -> err_desalineado=1, if_valid stays 0, outputs frozen for 10 cycles; rst_n=0 for one edge clears to pc=0, err=0.
- rst_n=0 for one edge during a stall at pc=32 -> pc=RESET_PC, if_valid=0 and all IF/ID fields 0 on that edge.
